// File: rtl/microsequencer_pkg.sv
// Shared sequencer definitions: FSM state encoding, IR opcodes and microcode entry points.
// Entry offsets are 6 bits wide, matching the microcode ROM address.
package sequencerdefs;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  localparam logic [4:0] OP_CLR  = 5'h00;
  localparam logic [4:0] OP_LDI  = 5'h01;
  localparam logic [4:0] OP_LD   = 5'h02;
  localparam logic [4:0] OP_ST   = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h04;
  localparam logic [4:0] OP_JMP  = 5'h05;
  localparam logic [4:0] OP_BZ   = 5'h06;
  localparam logic [4:0] OP_BN   = 5'h07;
  localparam logic [4:0] OP_BC   = 5'h08;
  localparam logic [4:0] OP_INC  = 5'h09;
  localparam logic [4:0] OP_CMPI = 5'h0a;
  localparam logic [4:0] OP_CMP  = 5'h0b;
  localparam logic [4:0] OP_SUB  = 5'h0c;
  localparam logic [4:0] OP_XOR  = 5'h0d;
  localparam logic [4:0] OP_NOR  = 5'h0e;
  localparam logic [4:0] OP_NAND = 5'h0f;
  localparam logic [4:0] OP_ADDI = 5'h10;
  localparam logic [4:0] OP_NOT  = 5'h11;
  localparam logic [4:0] OP_SRA  = 5'h12;
  localparam logic [4:0] OP_SLA  = 5'h13;
  localparam logic [4:0] OP_HLT  = 5'h14;

  localparam logic [5:0] UC_CLR    = 6'h02;
  localparam logic [5:0] UC_LDI    = 6'h03;
  localparam logic [5:0] UC_LD     = 6'h04;
  localparam logic [5:0] UC_ST     = 6'h08;
  localparam logic [5:0] UC_ADD    = 6'h0a;
  localparam logic [5:0] UC_JMP    = 6'h0e;
  localparam logic [5:0] UC_NOJMP  = 6'h0f;
  localparam logic [5:0] UC_INC    = 6'h10;
  localparam logic [5:0] UC_CMPI   = 6'h11;
  localparam logic [5:0] UC_CMP    = 6'h12;
  localparam logic [5:0] UC_SUB    = 6'h16;
  localparam logic [5:0] UC_XOR    = 6'h1a;
  localparam logic [5:0] UC_NOR    = 6'h1e;
  localparam logic [5:0] UC_NAND   = 6'h22;
  localparam logic [5:0] UC_ADDI   = 6'h26;
  localparam logic [5:0] UC_NOT    = 6'h27;
  localparam logic [5:0] UC_SRA    = 6'h28;
  localparam logic [5:0] UC_SLA    = 6'h29;
  localparam logic [5:0] UC_HALT   = 6'h3f;

  // Conditional branches share the JMP microroutine when taken, fall through otherwise.
  function automatic logic [5:0] branch_target(input logic flag);
    return flag ? UC_JMP : UC_NOJMP;
  endfunction

endpackage

// File: rtl/microsequencer_dispatch.sv
// Combinational opcode+flags -> microcode entry offset; zero latency, no flow control.
// Unknown opcodes land on the halt trap.
module dispatch_decode
  import sequencerdefs::*;
#(
  parameter int                    OFFSET_WIDTH = 6,
  parameter int                    OPCODE_WIDTH = 5,
  parameter logic [OFFSET_WIDTH-1:0] HALT_OFFSET = {OFFSET_WIDTH{1'b1}}
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_z,
  input  logic                    flag_n,
  input  logic                    flag_c,
  output logic [OFFSET_WIDTH-1:0] target
);

  logic [5:0] uc;
  logic       known;

  always_comb begin
    uc    = UC_HALT;
    known = 1'b1;
    case (opcode)
      OPCODE_WIDTH'(OP_CLR):  uc = UC_CLR;
      OPCODE_WIDTH'(OP_LDI):  uc = UC_LDI;
      OPCODE_WIDTH'(OP_LD):   uc = UC_LD;
      OPCODE_WIDTH'(OP_ST):   uc = UC_ST;
      OPCODE_WIDTH'(OP_ADD):  uc = UC_ADD;
      OPCODE_WIDTH'(OP_JMP):  uc = UC_JMP;
      OPCODE_WIDTH'(OP_BZ):   uc = branch_target(flag_z);
      OPCODE_WIDTH'(OP_BN):   uc = branch_target(flag_n);
      OPCODE_WIDTH'(OP_BC):   uc = branch_target(flag_c);
      OPCODE_WIDTH'(OP_INC):  uc = UC_INC;
      OPCODE_WIDTH'(OP_CMPI): uc = UC_CMPI;
      OPCODE_WIDTH'(OP_CMP):  uc = UC_CMP;
      OPCODE_WIDTH'(OP_SUB):  uc = UC_SUB;
      OPCODE_WIDTH'(OP_XOR):  uc = UC_XOR;
      OPCODE_WIDTH'(OP_NOR):  uc = UC_NOR;
      OPCODE_WIDTH'(OP_NAND): uc = UC_NAND;
      OPCODE_WIDTH'(OP_ADDI): uc = UC_ADDI;
      OPCODE_WIDTH'(OP_NOT):  uc = UC_NOT;
      OPCODE_WIDTH'(OP_SRA):  uc = UC_SRA;
      OPCODE_WIDTH'(OP_SLA):  uc = UC_SLA;
      OPCODE_WIDTH'(OP_HLT):  uc = UC_HALT;
      default:                known = 1'b0;
    endcase
    target = known ? OFFSET_WIDTH'(uc) : HALT_OFFSET;
  end

endmodule

// File: rtl/microsequencer.sv
// Microcode address sequencer: ISSUE/EXEC pair per microword (2 cycles), registered offset.
// Stalls in EXEC/WAIT while a memory microword lacks mem_ready; halt trap exits only on rst.
module microsequencer
  import sequencerdefs::*;
#(
  parameter int                      OFFSET_WIDTH = 6,
  parameter int                      OPCODE_WIDTH = 5,
  parameter logic [OFFSET_WIDTH-1:0] FETCH_OFFSET = 6'h00,
  parameter logic [OFFSET_WIDTH-1:0] HALT_OFFSET  = 6'h3f
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mc_seq,
  input  logic [OFFSET_WIDTH-1:0] mc_next,
  input  logic                    mc_mem,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_z,
  input  logic                    flag_n,
  input  logic                    flag_c,
  input  logic                    mem_ready,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    mc_valid,
  output logic                    halted
);

  seq_state_t              state;
  logic [OFFSET_WIDTH-1:0] disp_target;
  logic [OFFSET_WIDTH-1:0] next_addr;
  logic                    advance;

  dispatch_decode #(
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .HALT_OFFSET  (HALT_OFFSET)
  ) u_dispatch (
    .opcode (opcode),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c),
    .target (disp_target)
  );

  assign next_addr = mc_seq ? mc_next : disp_target;

  // The offset moves on only when the current microword has finished, including its memory access.
  assign advance = ((state == ST_EXEC) && !(mc_mem && !mem_ready)) ||
                   ((state == ST_WAIT) && mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ISSUE;
      offset   <= FETCH_OFFSET;
      mc_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: begin
          state    <= ST_EXEC;
          mc_valid <= 1'b1;
        end
        ST_EXEC, ST_WAIT: begin
          mc_valid <= 1'b0;
          if (advance) begin
            offset <= next_addr;
            if (next_addr == HALT_OFFSET) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_HALT: begin
          offset   <= HALT_OFFSET;
          mc_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: begin
          state    <= ST_ISSUE;
          mc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: reset, dispatch, branches, memory stalls, halt trap, async reset.
module tb_microsequencer;
  import sequencerdefs::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mc_seq;
  logic [5:0] mc_next;
  logic       mc_mem;
  logic [4:0] opcode;
  logic       flag_z, flag_n, flag_c;
  logic       mem_ready;
  logic [5:0] offset;
  logic       mc_valid;
  logic       halted;

  int errors = 0;
  int checks = 0;

  microsequencer dut (
    .clk       (clk),
    .rst       (rst),
    .mc_seq    (mc_seq),
    .mc_next   (mc_next),
    .mc_mem    (mc_mem),
    .opcode    (opcode),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .mem_ready (mem_ready),
    .offset    (offset),
    .mc_valid  (mc_valid),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic seq, input logic [5:0] nxt, input logic [4:0] op,
                       input logic z, input logic n, input logic c,
                       input logic mem, input logic rdy);
    mc_seq    = seq;
    mc_next   = nxt;
    opcode    = op;
    flag_z    = z;
    flag_n    = n;
    flag_c    = c;
    mc_mem    = mem;
    mem_ready = rdy;
  endtask

  // One non-memory microword starting from ISSUE: EXEC strobe, then the new offset.
  task automatic uop(input string tag, input logic seq, input logic [5:0] nxt, input logic [4:0] op,
                     input logic z, input logic n, input logic c, input logic [5:0] exp);
    drive(seq, nxt, op, z, n, c, 1'b0, 1'b0);
    step();
    check({tag, "_exec_valid"}, 32'(mc_valid), 32'd1);
    step();
    check({tag, "_offset"}, 32'(offset), 32'(exp));
    check({tag, "_valid_after"}, 32'(mc_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 6'h01, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("rst_offset", 32'(offset), 32'h00);
    check("rst_valid", 32'(mc_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Reset release: ISSUE (valid 0), EXEC (valid 1), then mc_next taken.
    rst = 1'b0;
    check("rel_issue_valid", 32'(mc_valid), 32'd0);
    step();
    check("rel_exec_valid", 32'(mc_valid), 32'd1);
    check("rel_exec_offset", 32'(offset), 32'h00);
    check("rel_exec_halted", 32'(halted), 32'd0);
    step();
    check("seq_next_01", 32'(offset), 32'h01);
    check("seq_next_valid", 32'(mc_valid), 32'd0);

    uop("add",   1'b0, 6'h00, 5'h04, 1'b0, 1'b0, 1'b0, 6'h0a);
    uop("bz_t",  1'b0, 6'h00, 5'h06, 1'b1, 1'b0, 1'b0, 6'h0e);
    uop("bz_nt", 1'b0, 6'h00, 5'h06, 1'b0, 1'b1, 1'b1, 6'h0f);
    uop("bn_t",  1'b0, 6'h00, 5'h07, 1'b0, 1'b1, 1'b0, 6'h0e);
    uop("bn_nt", 1'b0, 6'h00, 5'h07, 1'b1, 1'b0, 1'b1, 6'h0f);
    uop("bc_t",  1'b0, 6'h00, 5'h08, 1'b0, 1'b0, 1'b1, 6'h0e);
    uop("bc_nt", 1'b0, 6'h00, 5'h08, 1'b1, 1'b1, 1'b0, 6'h0f);
    uop("clr",   1'b0, 6'h00, 5'h00, 1'b0, 1'b0, 1'b0, 6'h02);
    uop("st",    1'b0, 6'h00, 5'h03, 1'b0, 1'b0, 1'b0, 6'h08);
    uop("nand",  1'b0, 6'h00, 5'h0f, 1'b0, 1'b0, 1'b0, 6'h22);
    uop("seq_ovr", 1'b1, 6'h2c, 5'h04, 1'b0, 1'b0, 1'b0, 6'h2c);
    uop("sla",   1'b0, 6'h00, 5'h13, 1'b0, 1'b0, 1'b0, 6'h29);

    // Memory stall: EXEC plus three WAIT cycles with mem_ready low.
    drive(1'b1, 6'h05, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("stall_exec_valid", 32'(mc_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_wait_offset", 32'(offset), 32'h29);
      check("stall_wait_valid", 32'(mc_valid), 32'd0);
    end
    mem_ready = 1'b1;
    step();
    check("stall_exit_offset", 32'(offset), 32'h05);
    check("stall_exit_valid", 32'(mc_valid), 32'd0);

    // Memory microword with mem_ready already high costs no extra cycle.
    drive(1'b1, 6'h07, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("mem_rdy_exec_valid", 32'(mc_valid), 32'd1);
    step();
    check("mem_rdy_offset", 32'(offset), 32'h07);

    // Dispatch resolved on WAIT exit.
    drive(1'b0, 6'h00, 5'h0c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("wdisp_exec_valid", 32'(mc_valid), 32'd1);
    step();
    check("wdisp_wait_offset", 32'(offset), 32'h07);
    mem_ready = 1'b1;
    step();
    check("wdisp_exit_offset", 32'(offset), 32'h16);

    // Asynchronous reset while in WAIT, applied between clock edges.
    drive(1'b1, 6'h09, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    check("arst_pre_offset", 32'(offset), 32'h16);
    check("arst_pre_state", 32'(dut.state), 32'(ST_WAIT));
    #2;
    rst = 1'b1;
    #1;
    check("arst_offset", 32'(offset), 32'h00);
    check("arst_state", 32'(dut.state), 32'(ST_ISSUE));
    check("arst_valid", 32'(mc_valid), 32'd0);
    #1;
    rst = 1'b0;
    uop("post_arst", 1'b1, 6'h0b, 5'h00, 1'b0, 1'b0, 1'b0, 6'h0b);

    // HLT opcode: trap latched for 20 cycles whatever the inputs do.
    uop("hlt", 1'b0, 6'h00, 5'h14, 1'b0, 1'b0, 1'b0, 6'h3f);
    check("hlt_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 6'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      step();
      check("hold_offset", 32'(offset), 32'h3f);
      check("hold_halted", 32'(halted), 32'd1);
      check("hold_valid", 32'(mc_valid), 32'd0);
    end
    rst = 1'b1;
    #1;
    check("hrst_offset", 32'(offset), 32'h00);
    check("hrst_halted", 32'(halted), 32'd0);
    step();
    rst = 1'b0;

    // Illegal opcode traps to the halt offset.
    uop("ill_1f", 1'b0, 6'h00, 5'h1f, 1'b1, 1'b1, 1'b1, 6'h3f);
    check("ill_1f_halted", 32'(halted), 32'd1);
    drive(1'b1, 6'h01, 5'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    step();
    check("ill_hold_offset", 32'(offset), 32'h3f);
    rst = 1'b1;
    step();
    rst = 1'b0;

    uop("ill_15", 1'b0, 6'h00, 5'h15, 1'b0, 1'b0, 1'b0, 6'h3f);
    check("ill_15_halted", 32'(halted), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("pre_seqhalt_halted", 32'(halted), 32'd0);

    uop("seq_halt", 1'b1, 6'h3f, 5'h04, 1'b0, 1'b0, 1'b0, 6'h3f);
    check("seq_halt_halted", 32'(halted), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
